mem_word_transform: RTL and testbench

Parametrised memory-to-memory word transform engine. On `start` it streams `ceil(size/BYTES)` words from a source region to a destination region of a shared single-port synchronous RAM, applying a per-job byte transform: rotate left/right by N bytes, byte-reverse, or copy. It is the generalised successor of the fixed 32-bit rotate-left-by-one-byte engine. It adds configurable data width, read latency and transform mode, a correct word count, and a held `done` with `busy` status.

---
 rtl/mem_word_transform.sv | 183 ++++++++++++++++++
 tb/tb_mem_word_transform.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_transform.sv
// Memory-to-memory word transform engine: streams ceil(size/BYTES) words from src to dst
// through a single-port synchronous RAM, applying rotate / byte-reverse / copy per word.
module mem_word_transform #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned BYTES       = DATA_WIDTH / 8,
    localparam int unsigned ROT_W       = $clog2(BYTES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           message_addr,
    input  logic [31:0]           output_addr,
    input  logic [31:0]           size,
    input  logic [1:0]            mode,
    input  logic [ROT_W-1:0]      rot_bytes,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_clk,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]           i_q, i_d;
    logic [2:0]            wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [1:0]            mode_q, mode_d;
    logic [ROT_W-1:0]      rot_q, rot_d;
    logic [31:0]           nwords_q, nwords_d;
    logic [32:0]           nwords_full;
    logic                  unused_addr_hi;

    // Only the low ADDR_WIDTH address bits address the RAM.
    assign unused_addr_hi = ^{message_addr[31:ADDR_WIDTH], output_addr[31:ADDR_WIDTH]};

    // 33-bit word count so size near 2^32 cannot overflow the round-up.
    assign nwords_full = (33'(size) + 33'(BYTES - 1)) / 33'(BYTES);

    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] din,
                                                    input logic [1:0]            m,
                                                    input logic [ROT_W-1:0]      k);
        logic [2*DATA_WIDTH-1:0] dbl;
        logic [DATA_WIDTH-1:0]   dout;
        dbl  = '0;
        dout = din;
        case (m)
            2'b00: begin
                dbl  = {din, din} << (8 * k);
                dout = dbl[2*DATA_WIDTH-1 -: DATA_WIDTH];
            end
            2'b01: begin
                dbl  = {din, din} >> (8 * k);
                dout = dbl[DATA_WIDTH-1:0];
            end
            2'b10: begin
                for (int j = 0; j < int'(BYTES); j++) begin
                    dout[8*j +: 8] = din[8*(int'(BYTES)-1-j) +: 8];
                end
            end
            default: dout = din;
        endcase
        return dout;
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = done_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_d      = i_q;
        wcnt_d   = wcnt_q;
        src_d    = src_q;
        dst_d    = dst_q;
        mode_d   = mode_q;
        rot_d    = rot_q;
        nwords_d = nwords_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d    = message_addr[ADDR_WIDTH-1:0];
                    dst_d    = output_addr[ADDR_WIDTH-1:0];
                    mode_d   = mode;
                    rot_d    = rot_bytes;
                    nwords_d = 32'(nwords_full);
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    i_d      = '0;
                    wcnt_d   = '0;
                    if (nwords_d == 32'd0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD;
                        addr_d  = message_addr[ADDR_WIDTH-1:0];
                    end
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == 3'(READ_LATENCY - 1)) begin
                    state_d = S_WR;
                    we_d    = 1'b1;
                    addr_d  = dst_q + ADDR_WIDTH'(i_q);
                    wdata_d = xform(mem_read_data, mode_q, rot_q);
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_WR: begin
                i_d = i_q + 32'd1;
                if (33'(i_q) + 33'd1 == 33'(nwords_q)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RD;
                    addr_d  = src_q + ADDR_WIDTH'(i_d);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_q      <= '0;
            wcnt_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            mode_q   <= '0;
            rot_q    <= '0;
            nwords_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            i_q      <= i_d;
            wcnt_q   <= wcnt_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            mode_q   <= mode_d;
            rot_q    <= rot_d;
            nwords_q <= nwords_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_word_transform.sv
// Directed bench for mem_word_transform: one instance at read latency 1, one at latency 3,
// each with its own behavioural RAM.
module tb_mem_word_transform;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start1, start3;
    logic [31:0]   message_addr, output_addr, size;
    logic [1:0]    mode, rot_bytes;

    logic          busy1, done1, mclk1, we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd1, rd1;
    logic          busy3, done3, mclk3, we3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] wd3, rd3;

    logic [DW-1:0] mem1 [0:65535];
    logic [DW-1:0] mem3 [0:65535];
    logic [DW-1:0] p3 [0:2];

    int we_cnt1 = 0;
    int cyc3 = 0;
    int wr_cyc3[$];
    int n_checks = 0;
    int n_pass = 0;
    int e, b;

    logic [1:0]  tm [6]   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
    logic [1:0]  tk [6]   = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2};
    logic [31:0] texp [6] = '{32'h44112233, 32'h44332211, 32'h11223344,
                              32'h11223344, 32'h44112233, 32'h33441122};

    always #5 clk = ~clk;

    mem_word_transform #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .message_addr(message_addr), .output_addr(output_addr), .size(size),
        .mode(mode), .rot_bytes(rot_bytes), .busy(busy1), .done(done1),
        .mem_clk(mclk1), .mem_we(we1), .mem_addr(addr1),
        .mem_write_data(wd1), .mem_read_data(rd1)
    );

    mem_word_transform #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3),
        .message_addr(message_addr), .output_addr(output_addr), .size(size),
        .mode(mode), .rot_bytes(rot_bytes), .busy(busy3), .done(done3),
        .mem_clk(mclk3), .mem_we(we3), .mem_addr(addr3),
        .mem_write_data(wd3), .mem_read_data(rd3)
    );

    // Latency-1 RAM: read returns the pre-write contents.
    always @(posedge mclk1) begin
        rd1 <= mem1[addr1];
        if (we1) begin
            mem1[addr1] = wd1;
            we_cnt1++;
        end
    end

    // Latency-3 RAM with a write-cycle log.
    always @(posedge mclk3) begin
        p3[2] <= p3[1];
        p3[1] <= p3[0];
        p3[0] <= mem3[addr3];
        cyc3++;
        if (we3) begin
            mem3[addr3] = wd3;
            wr_cyc3.push_back(cyc3);
        end
    end
    assign rd3 = p3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_job(input bit sel, input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] sz, input logic [1:0] m, input logic [1:0] k);
        @(negedge clk);
        message_addr = src;
        output_addr  = dst;
        size         = sz;
        mode         = m;
        rot_bytes    = k;
        if (sel) start3 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts edges from the accept edge (edge 1) until done is seen high.
    task automatic wait_done(input bit sel, input int first, output int edges);
        edges = first;
        while (((sel ? done3 : done1) !== 1'b1) && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic job(input bit sel, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] sz, input logic [1:0] m, input logic [1:0] k,
                       output int edges);
        start_job(sel, src, dst, sz, m, k);
        wait_done(sel, 1, edges);
    endtask

    initial begin
        reset_n = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        message_addr = '0;
        output_addr = '0;
        size = '0;
        mode = '0;
        rot_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_we", we1, 0);
        check("rst_addr", addr1, 0);
        check("rst_wdata", wd1, 0);
        check("rst_busy3", busy3, 0);
        @(negedge clk) reset_n = 1'b1;

        // Legacy rotate-left by one byte
        mem1[16'h10] = 32'h11223344;
        mem1[16'h11] = 32'hAABBCCDD;
        b = we_cnt1;
        job(0, 32'h10, 32'h20, 32'd8, 2'd0, 2'd1, e);
        check("legacy_latency", e, 8);
        check("legacy_w0", mem1[16'h20], 32'h22334411);
        check("legacy_w1", mem1[16'h21], 32'hBBCCDDAA);
        check("legacy_pulses", we_cnt1 - b, 2);
        check("legacy_busy", busy1, 0);

        // Transform modes on a single word
        mem1[16'h30] = 32'h11223344;
        for (int i = 0; i < 6; i++) begin
            job(0, 32'h30, 32'h40 + i, 32'd4, tm[i], tk[i], e);
            check($sformatf("mode%0d_k%0d", tm[i], tk[i]), mem1[16'h40 + i], texp[i]);
            check($sformatf("mode_lat%0d", i), e, 5);
        end

        // size = 0
        b = we_cnt1;
        job(0, 32'h10, 32'h48, 32'd0, 2'd3, 2'd0, e);
        check("size0_latency", e, 2);
        check("size0_pulses", we_cnt1 - b, 0);

        // size = 5: partial final word transformed in full
        mem1[16'h50] = 32'h01020304;
        mem1[16'h51] = 32'h05060708;
        mem1[16'h52] = 32'hDEADBEEF;
        mem1[16'h60] = '0;
        mem1[16'h61] = '0;
        mem1[16'h62] = '0;
        b = we_cnt1;
        job(0, 32'h50, 32'h60, 32'd5, 2'd0, 2'd1, e);
        check("size5_latency", e, 8);
        check("size5_pulses", we_cnt1 - b, 2);
        check("size5_w0", mem1[16'h60], 32'h02030401);
        check("size5_w1", mem1[16'h61], 32'h06070805);
        check("size5_w2", mem1[16'h62], 32'h0);

        // size = 1
        mem1[16'h68] = '0;
        b = we_cnt1;
        job(0, 32'h50, 32'h68, 32'd1, 2'd2, 2'd0, e);
        check("size1_pulses", we_cnt1 - b, 1);
        check("size1_w0", mem1[16'h68], 32'h04030201);

        // Address wrap with read latency 3; upper address bits ignored
        mem3[16'hFFFF] = 32'h11223344;
        mem3[16'h0000] = 32'hAABBCCDD;
        mem3[16'h0100] = '0;
        mem3[16'h0101] = '0;
        wr_cyc3.delete();
        job(1, 32'hABCD_FFFF, 32'h100, 32'd8, 2'd2, 2'd0, e);
        check("wrap_latency", e, 12);
        check("wrap_w0", mem3[16'h0100], 32'h44332211);
        check("wrap_w1", mem3[16'h0101], 32'hDDCCBBAA);
        check("wrap_pulses", wr_cyc3.size(), 2);
        if (wr_cyc3.size() == 2) check("wrap_word_cycles", wr_cyc3[1] - wr_cyc3[0], 5);

        // start re-pulsed mid-job with different parameters
        mem1[16'h70] = '0;
        mem1[16'h71] = '0;
        mem1[16'h80] = '0;
        start_job(0, 32'h10, 32'h70, 32'd8, 2'd0, 2'd1);
        @(posedge clk);
        #1;
        message_addr = 32'h30;
        output_addr = 32'h80;
        size = 32'd4;
        mode = 2'd2;
        rot_bytes = 2'd3;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(0, 3, e);
        check("proto_latency", e, 8);
        check("proto_w0", mem1[16'h70], 32'h22334411);
        check("proto_w1", mem1[16'h71], 32'hBBCCDDAA);
        check("proto_ignored", mem1[16'h80], 32'h0);

        // done held until next accepted start
        repeat (5) @(posedge clk);
        #1;
        check("done_held", done1, 1);
        check("busy_low_held", busy1, 0);
        start_job(0, 32'h10, 32'h90, 32'd8, 2'd0, 2'd1);
        check("done_clr_on_accept", done1, 0);
        check("busy_on_accept", busy1, 1);
        wait_done(0, 1, e);
        check("second_w1", mem1[16'h91], 32'hBBCCDDAA);

        // Reset during WR of word 1
        mem1[16'hA0] = '0;
        mem1[16'hA1] = '0;
        start_job(0, 32'h10, 32'hA0, 32'd8, 2'd0, 2'd1);
        repeat (5) @(posedge clk);
        #1;
        check("mid_we_before_rst", we1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_we", we1, 0);
        check("rst_async_busy", busy1, 0);
        check("rst_async_done", done1, 0);
        check("rst_async_addr", addr1, 0);
        @(posedge clk);
        #1;
        check("rst_w0_kept", mem1[16'hA0], 32'h22334411);
        check("rst_w1_abandoned", mem1[16'hA1], 32'h0);
        @(negedge clk) reset_n = 1'b1;
        job(0, 32'h10, 32'hB0, 32'd8, 2'd0, 2'd1, e);
        check("post_rst_latency", e, 8);
        check("post_rst_w0", mem1[16'hB0], 32'h22334411);
        check("post_rst_w1", mem1[16'hB1], 32'hBBCCDDAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
